// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: D = A - B (mod 2^WIDTH) with borrow-out Br.
//   One difference bit is produced per clock, LSB first, through a single
//   borrow flip-flop. A start accepted in IDLE captures the operands. The
//   block then spends WIDTH cycles in RUN, followed by a single DONE cycle.
//
//   Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
//   output V. With the macro undefined, V and its MSB capture are absent.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   start    in   1      operation request, sampled only in IDLE
//   A        in   WIDTH  minuend, captured on an accepted start
//   B        in   WIDTH  subtrahend, captured on an accepted start
//   busy     out  1      high while the serial loop runs (WIDTH cycles)
//   done     out  1      one-cycle pulse; D/Br (and V) valid from this cycle
//   D        out  WIDTH  registered difference, held until the next completion
//   Br       out  1      registered final borrow (A < B unsigned)
//   V        out  1      registered signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Br
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // The minuend register doubles as the result shift register: each step
    // consumes sa_q[0] and shifts the new difference bit in at the MSB, so
    // after WIDTH steps it holds the assembled difference.
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             bf_q;
    logic [CNT_W-1:0] cnt_q;

    logic             d_bit;
    logic             bf_next;
    logic             last_bit;
    logic             load;

    // One full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic diff;
        logic bout;
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, diff};
    endfunction

    assign {bf_next, d_bit} = full_sub(sa_q[0], sb_q[0], bf_q);
    assign last_bit         = (cnt_q == CNT_W'(WIDTH - 1));
    assign load             = (state_q == S_IDLE) && start;

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Serial datapath: operand shift registers, borrow flip-flop, bit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa_q  <= '0;
            sb_q  <= '0;
            bf_q  <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            sa_q  <= A;
            sb_q  <= B;
            bf_q  <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == S_RUN) begin
            sa_q  <= {d_bit, sa_q[WIDTH-1:1]};
            sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
            bf_q  <= bf_next;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are consumed by the shift, so they are kept aside
    // for the overflow decision at the final step.
    logic a_msb_q;
    logic b_msb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (load) begin
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
        end
    end
`endif

    // Result registers: updated only on the final serial step and held
    // across later starts until the next completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            D  <= '0;
            Br <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            V  <= 1'b0;
`endif
        end else if ((state_q == S_RUN) && last_bit) begin
            D  <= {d_bit, sa_q[WIDTH-1:1]};
            Br <= bf_next;
`ifdef SERIAL_SUB_OVF_EN
            // d_bit is the result MSB on the final step.
            V  <= (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Br;
`ifdef SERIAL_SUB_OVF_EN
    logic         V;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .D       (D),
        .Br      (Br)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .V       (V)
`endif
    );

    // Reference: unsigned difference with borrow, computed as plain arithmetic.
    function automatic logic [W:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // Reference: signed overflow from two's-complement integer values.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        int d;
        ia = a[W-1] ? int'(a) - (1 << W) : int'(a);
        ib = b[W-1] ? int'(b) - (1 << W) : int'(b);
        d  = ia - ib;
        return (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One operation from an IDLE cycle. In detail mode every RUN cycle is
    // checked, start is pulsed while busy and during DONE (both must be
    // ignored), and the held result is checked in IDLE afterwards.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit detail);
        logic [W:0] e;
        e     = ref_diff(a, b);
        A     = a;
        B     = b;
        start = 1'b1;
        tick;
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        for (int i = 1; i <= W; i++) begin
            if (detail) begin
                check("busy_in_run", busy, 1);
                check("done_in_run", done, 0);
            end
            start = detail && (i == 2 || i == 3);
            A     = W'($urandom);
            B     = W'($urandom);
            tick;
        end
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        check("D_result", D, e[W-1:0]);
        check("Br_result", Br, e[W]);
`ifdef SERIAL_SUB_OVF_EN
        check("V_result", V, ref_ovf(a, b));
`endif
        if (detail) begin
            start = 1'b1;
            tick;
            start = 1'b0;
            check("done_one_cycle", done, 0);
            check("start_in_done_ignored", busy, 0);
            check("D_held", D, e[W-1:0]);
            check("Br_held", Br, e[W]);
        end else begin
            tick;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W:0] e;
        bit         saw;

        reset_n = 1'b1;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_D", D, 0);
        check("rst_Br", Br, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_V", V, 0);
`endif
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Directed cases
        run_op(4'd9, 4'd5, 1'b1);
        run_op(4'd5, 4'd9, 1'b1);
        run_op(4'd0, 4'd0, 1'b1);
        run_op(4'd15, 4'd15, 1'b1);
        run_op(4'd8, 4'd1, 1'b1);
        run_op(4'd7, 4'd15, 1'b1);
        run_op(4'd6, 4'd3, 1'b1);

        // start held high with new operands through RUN and DONE
        A     = 4'd3;
        B     = 4'd1;
        start = 1'b1;
        tick;
        A     = 4'd7;
        B     = 4'd7;
        for (int i = 0; i < W; i++) tick;
        check("held_first_done", done, 1);
        check("held_first_D", D, 2);
        check("held_first_Br", Br, 0);
        tick;
        check("held_idle_busy", busy, 0);
        check("held_idle_done", done, 0);
        tick;
        check("held_second_busy", busy, 1);
        for (int i = 0; i < W; i++) tick;
        check("held_second_done", done, 1);
        check("held_second_D", D, 0);
        check("held_second_Br", Br, 0);
        start = 1'b0;
        tick;

        // Asynchronous reset in the middle of RUN
        run_op(4'd9, 4'd5, 1'b0);
        A     = 4'd9;
        B     = 4'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #2 reset_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_D", D, 0);
        check("midrun_rst_Br", Br, 0);
        tick;
        reset_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            tick;
            saw = saw | done | busy;
        end
        check("no_done_after_rst", saw, 0);

        // Randomized operations with full cycle checks
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'b1);
        end

        // All operand pairs back-to-back
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op(W'(a), W'(b), 1'b0);
            end
        end

        e = ref_diff(4'd15, 4'd15);
        check("final_D_held", D, e[W-1:0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
